// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control decoder with mult/div sequencing.
// Decodes ALUop/func into an ALU control word and holds decode while a multi-cycle op runs.
module alu_control_seq #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6,
    parameter bit EXT_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] ALUop,
    input  logic [5:0] func,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] ALUctr,
    output logic       SllFlag,
    output logic       ShiftFlag,
    output logic       md_start,
    output logic       md_busy,
    output logic       illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_MD
    } state_t;

    typedef struct packed {
        logic [3:0] ctr;
        logic       sll;
        logic       shift;
        logic       bad;
        logic       md;
        logic       is_div;
    } dec_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    // Extended funcs (and/srl/mult/div) decode as illegal when EXT_EN is off.
    function automatic dec_t decode(input logic [1:0] op, input logic [5:0] fn);
        dec_t d;
        d = '0;
        case (op)
            2'b00: d.ctr = 4'b0010;
            2'b01: d.ctr = 4'b0110;
            2'b10: begin
                case (fn)
                    6'b100000, 6'b100001: d.ctr = 4'b0010;
                    6'b100010, 6'b100011: d.ctr = 4'b0110;
                    6'b101010:            d.ctr = 4'b0111;
                    6'b101001:            d.ctr = 4'b0101;
                    6'b100101:            d.ctr = 4'b0001;
                    6'b000000: begin
                        d.ctr   = 4'b1000;
                        d.sll   = 1'b1;
                        d.shift = 1'b1;
                    end
                    6'b100100: begin
                        if (EXT_EN) d.ctr = 4'b0000;
                        else        d.bad = 1'b1;
                    end
                    6'b000010: begin
                        if (EXT_EN) begin
                            d.ctr   = 4'b1001;
                            d.shift = 1'b1;
                        end else begin
                            d.bad = 1'b1;
                        end
                    end
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        if (EXT_EN) begin
                            d.ctr    = {2'b10, fn[1:0]} + 4'b0010;
                            d.md     = 1'b1;
                            d.is_div = fn[1];
                        end else begin
                            d.bad = 1'b1;
                        end
                    end
                    default: d.bad = 1'b1;
                endcase
            end
            default: d.bad = 1'b1;
        endcase
        return d;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] count;
    dec_t             dec;
    logic             accept;

    assign dec      = decode(ALUop, func);
    assign in_ready = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            ALUctr    <= 4'b0000;
            SllFlag   <= 1'b0;
            ShiftFlag <= 1'b0;
            md_start  <= 1'b0;
            md_busy   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            md_start <= 1'b0;
            case (state)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        ALUctr    <= dec.ctr;
                        SllFlag   <= dec.sll;
                        ShiftFlag <= dec.shift;
                        illegal   <= dec.bad;
                        if (dec.md) begin
                            state     <= S_MD;
                            md_start  <= 1'b1;
                            md_busy   <= 1'b1;
                            out_valid <= 1'b0;
                            count     <= dec.is_div ? DIV_LOAD : MULT_LOAD;
                        end else begin
                            state     <= S_HOLD;
                            out_valid <= 1'b1;
                        end
                    end else if (state == S_HOLD && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_MD: begin
                    // Counter holds remaining cycles minus one; zero means this is the last.
                    if (count == '0) begin
                        state     <= S_HOLD;
                        md_busy   <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    md_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed self-checking bench for alu_control_seq: main instance plus EXT_EN=0
// and single-cycle mult/div variants sharing the decode inputs.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_valid_x = 1'b0;
    logic       in_valid_n = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] alu_op = 2'b00;
    logic [5:0] func = 6'b000000;

    logic       in_ready, out_valid, sll_flag, shift_flag, md_start, md_busy, illegal;
    logic [3:0] alu_ctr;
    logic       in_ready_x, out_valid_x, sll_flag_x, shift_flag_x, md_start_x, md_busy_x, illegal_x;
    logic [3:0] alu_ctr_x;
    logic       in_ready_n, out_valid_n, sll_flag_n, shift_flag_n, md_start_n, md_busy_n, illegal_n;
    logic [3:0] alu_ctr_n;

    int checks = 0;
    int errors = 0;

    alu_control_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(alu_op), .func(func), .out_valid(out_valid), .out_ready(out_ready),
        .ALUctr(alu_ctr), .SllFlag(sll_flag), .ShiftFlag(shift_flag),
        .md_start(md_start), .md_busy(md_busy), .illegal(illegal)
    );

    alu_control_seq #(.EXT_EN(1'b0)) dut_x (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(in_ready_x),
        .ALUop(alu_op), .func(func), .out_valid(out_valid_x), .out_ready(out_ready),
        .ALUctr(alu_ctr_x), .SllFlag(sll_flag_x), .ShiftFlag(shift_flag_x),
        .md_start(md_start_x), .md_busy(md_busy_x), .illegal(illegal_x)
    );

    alu_control_seq #(.MULT_CYCLES(1), .DIV_CYCLES(1), .CNT_W(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_n), .in_ready(in_ready_n),
        .ALUop(alu_op), .func(func), .out_valid(out_valid_n), .out_ready(out_ready),
        .ALUctr(alu_ctr_n), .SllFlag(sll_flag_n), .ShiftFlag(shift_flag_n),
        .md_start(md_start_n), .md_busy(md_busy_n), .illegal(illegal_n)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single-cycle R-type table: func, expected ALUctr, sll/shift flags by index.
    logic [5:0] s_func [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b101010,
                                6'b101001, 6'b100101, 6'b100100, 6'b000010, 6'b000000};
    logic [3:0] s_ctr  [10] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0111,
                                4'b0101, 4'b0001, 4'b0000, 4'b1001, 4'b1000};
    logic [9:0] sll_mask   = 10'b10_0000_0000;
    logic [9:0] shift_mask = 10'b11_0000_0000;
    logic [5:0] m_func [4] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};
    logic [3:0] m_ctr  [4] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101};

    initial begin
        int seen;

        // Reset state
        tick;
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_ctr", alu_ctr, 4'b0000);
        check("rst_md_busy", md_busy, 0);
        check("rst_md_start", md_start, 0);
        check("rst_illegal", illegal, 0);
        check("rst_flags", {sll_flag, shift_flag}, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick;

        // I-type add/sub
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = 2'b00;
        tick;
        check("itype_add_valid", out_valid, 1);
        check("itype_add_ctr", alu_ctr, 4'b0010);
        alu_op = 2'b01;
        tick;
        check("itype_sub_ctr", alu_ctr, 4'b0110);
        check("itype_sub_illegal", illegal, 0);

        // Streaming R-type, one result per cycle
        alu_op = 2'b10;
        for (int i = 0; i < 10; i++) begin
            func = s_func[i];
            tick;
            check($sformatf("stream%0d_valid", i), out_valid, 1);
            check($sformatf("stream%0d_ctr", i), alu_ctr, s_ctr[i]);
            check($sformatf("stream%0d_sll", i), sll_flag, sll_mask[i]);
            check($sformatf("stream%0d_shift", i), shift_flag, shift_mask[i]);
            check($sformatf("stream%0d_illegal", i), illegal, 0);
            check($sformatf("stream%0d_in_ready", i), in_ready, 1);
        end
        in_valid = 1'b0;
        tick;
        check("drain_to_idle", out_valid, 0);

        // Illegal decodes
        in_valid = 1'b1;
        alu_op   = 2'b11;
        func     = 6'b100000;
        tick;
        check("ill_op11_illegal", illegal, 1);
        check("ill_op11_ctr", alu_ctr, 4'b0000);
        check("ill_op11_valid", out_valid, 1);
        check("ill_op11_busy", md_busy, 0);
        alu_op = 2'b10;
        func   = 6'b111111;
        tick;
        check("ill_func_illegal", illegal, 1);
        check("ill_func_ctr", alu_ctr, 4'b0000);
        check("ill_func_start", md_start, 0);
        func = 6'b100100;
        tick;
        check("and_legal", illegal, 0);
        check("and_ctr", alu_ctr, 4'b0000);
        in_valid   = 1'b0;
        in_valid_x = 1'b1;
        func       = 6'b011010;
        tick;
        check("noext_div_illegal", illegal_x, 1);
        check("noext_div_ctr", alu_ctr_x, 4'b0000);
        check("noext_div_start", md_start_x, 0);
        check("noext_div_busy", md_busy_x, 0);
        check("noext_div_valid", out_valid_x, 1);
        in_valid_x = 1'b0;
        func       = 6'b000010;
        in_valid_x = 1'b1;
        tick;
        check("noext_srl_illegal", illegal_x, 1);
        in_valid_x = 1'b0;
        tick;

        // Single-cycle mult/div unit: MD lasts exactly one cycle
        for (int i = 0; i < 4; i++) begin
            in_valid_n = 1'b1;
            func       = m_func[i];
            tick;
            check($sformatf("n1_%0d_start", i), md_start_n, 1);
            check($sformatf("n1_%0d_busy", i), md_busy_n, 1);
            check($sformatf("n1_%0d_early_valid", i), out_valid_n, 0);
            in_valid_n = 1'b0;
            tick;
            check($sformatf("n1_%0d_valid", i), out_valid_n, 1);
            check($sformatf("n1_%0d_ctr", i), alu_ctr_n, m_ctr[i]);
            check($sformatf("n1_%0d_busy_done", i), md_busy_n, 0);
            check($sformatf("n1_%0d_start_done", i), md_start_n, 0);
            tick;
        end

        // Multi-cycle mult on the main instance
        func     = 6'b011000;
        in_valid = 1'b1;
        check("mult_in_ready_idle", in_ready, 1);
        tick;
        in_valid = 1'b0;
        #1;
        check("mult_start", md_start, 1);
        check("mult_busy0", md_busy, 1);
        check("mult_in_ready0", in_ready, 0);
        check("mult_valid0", out_valid, 0);
        for (int i = 1; i < 4; i++) begin
            tick;
            check($sformatf("mult_start%0d", i), md_start, 0);
            check($sformatf("mult_busy%0d", i), md_busy, 1);
            check($sformatf("mult_in_ready%0d", i), in_ready, 0);
            check($sformatf("mult_valid%0d", i), out_valid, 0);
        end
        tick;
        check("mult_done_valid", out_valid, 1);
        check("mult_done_ctr", alu_ctr, 4'b1010);
        check("mult_done_busy", md_busy, 0);
        tick;
        check("mult_consumed", out_valid, 0);

        // Backpressure: sub held for 5 cycles, then back-to-back accept
        out_ready = 1'b0;
        in_valid  = 1'b1;
        func      = 6'b100010;
        tick;
        func = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), out_valid, 1);
            check($sformatf("bp%0d_ctr", i), alu_ctr, 4'b0110);
            check($sformatf("bp%0d_in_ready", i), in_ready, 0);
            tick;
        end
        check("bp_still_held", alu_ctr, 4'b0110);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        tick;
        check("bp_next_valid", out_valid, 1);
        check("bp_next_ctr", alu_ctr, 4'b0010);
        in_valid = 1'b0;
        tick;

        // Reset during a div countdown
        in_valid = 1'b1;
        func     = 6'b011010;
        tick;
        in_valid = 1'b0;
        check("div_start", md_start, 1);
        repeat (21) tick;
        check("div_busy_at10", md_busy, 1);
        check("div_no_valid_at10", out_valid, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ctr", alu_ctr, 4'b0000);
        check("midrst_busy", md_busy, 0);
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (out_valid || md_busy) seen++;
        end
        check("midrst_no_late_valid", 8'(seen), 0);
        check("midrst_in_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
